// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one simple dual-port RAM (1 write port, 1 registered read port)
// between two masters, A and B. The write and read channels each have their
// own round-robin arbiter, so one write and one read can reach the RAM in
// the same cycle. A read that targets the address being written in the same
// cycle is either stalled for a cycle (default) or served from a forward
// register holding the new write data (build macro WR_FORWARD_EN).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   {a,b}_wr_req/addr/data     write request, held until {a,b}_wr_gnt
//   {a,b}_wr_gnt               write accepted this cycle (combinational)
//   {a,b}_rd_req/addr          read request, held until {a,b}_rd_gnt
//   {a,b}_rd_gnt               read accepted this cycle (combinational)
//   {a,b}_rd_valid             rd_data belongs to that master this cycle
//   rd_data                    shared read-return data
//   ram_write_*/ram_read_*     RAM port connections; ram_read_data is valid
//                              the cycle after ram_read_enable
//
// Configuration macro: WR_FORWARD_EN (undefined by default).

module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_wr_req,
    input  logic [ADDR_W-1:0] a_wr_addr,
    input  logic [DATA_W-1:0] a_wr_data,
    output logic              a_wr_gnt,
    input  logic              a_rd_req,
    input  logic [ADDR_W-1:0] a_rd_addr,
    output logic              a_rd_gnt,
    output logic              a_rd_valid,
    input  logic              b_wr_req,
    input  logic [ADDR_W-1:0] b_wr_addr,
    input  logic [DATA_W-1:0] b_wr_data,
    output logic              b_wr_gnt,
    input  logic              b_rd_req,
    input  logic [ADDR_W-1:0] b_rd_addr,
    output logic              b_rd_gnt,
    output logic              b_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_enable,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data
);

    // 1 = B was the last winner, so A has priority on the next contention.
    logic wr_last_b;
    logic rd_last_b;

    logic a_wr_win, b_wr_win, wr_any, wr_sel_b;
    logic a_rd_cand, b_rd_cand, rd_any, rd_sel_b;
    logic collision, rd_ok;

    always_comb begin
        a_wr_win  = a_wr_req & (~b_wr_req | wr_last_b);
        b_wr_win  = b_wr_req & (~a_wr_req | ~wr_last_b);
        a_rd_cand = a_rd_req & (~b_rd_req | rd_last_b);
        b_rd_cand = b_rd_req & (~a_rd_req | ~rd_last_b);
    end

    // With no request on a channel the mux keeps pointing at the last
    // winner, so the RAM port sees that master's values.
    assign wr_any   = a_wr_win | b_wr_win;
    assign wr_sel_b = wr_any ? b_wr_win : wr_last_b;
    assign rd_any   = a_rd_cand | b_rd_cand;
    assign rd_sel_b = rd_any ? b_rd_cand : rd_last_b;

    assign ram_write_addr = wr_sel_b ? b_wr_addr : a_wr_addr;
    assign ram_write_data = wr_sel_b ? b_wr_data : a_wr_data;
    assign ram_read_addr  = rd_sel_b ? b_rd_addr : a_rd_addr;

    // The write always goes through; only the read side reacts to a clash.
    assign collision = wr_any & rd_any & (ram_read_addr == ram_write_addr);

`ifdef WR_FORWARD_EN
    assign rd_ok = 1'b1;
`else
    assign rd_ok = ~collision;
`endif

    assign a_wr_gnt         = rst_n & a_wr_win;
    assign b_wr_gnt         = rst_n & b_wr_win;
    assign ram_write_enable = rst_n & wr_any;
    assign a_rd_gnt         = rst_n & a_rd_cand & rd_ok;
    assign b_rd_gnt         = rst_n & b_rd_cand & rd_ok;
    // A forwarded read never touches the RAM read port.
    assign ram_read_enable  = rst_n & rd_any & ~collision;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_last_b  <= 1'b1;
            rd_last_b  <= 1'b1;
            a_rd_valid <= 1'b0;
            b_rd_valid <= 1'b0;
        end else begin
            if (a_wr_gnt | b_wr_gnt) wr_last_b <= b_wr_gnt;
            if (a_rd_gnt | b_rd_gnt) rd_last_b <= b_rd_gnt;
            a_rd_valid <= a_rd_gnt;
            b_rd_valid <= b_rd_gnt;
        end
    end

`ifdef WR_FORWARD_EN
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_data <= '0;
            fwd_hit  <= 1'b0;
        end else begin
            fwd_hit <= collision;
            if (collision) fwd_data <= ram_write_data;
        end
    end

    assign rd_data = fwd_hit ? fwd_data : ram_read_data;
`else
    assign rd_data = ram_read_data;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM plus a rule-level model of
// both arbiters and the read return, checked every cycle, alongside
// directed scenarios with literal expectations.
module tb_ram_port_arbiter;

`ifdef WR_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst_n;
    logic        a_wr_req, a_wr_gnt, a_rd_req, a_rd_gnt, a_rd_valid;
    logic        b_wr_req, b_wr_gnt, b_rd_req, b_rd_gnt, b_rd_valid;
    logic [9:0]  a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
    logic [15:0] a_wr_data, b_wr_data, rd_data;
    logic        ram_write_enable, ram_read_enable;
    logic [9:0]  ram_write_addr, ram_read_addr;
    logic [15:0] ram_write_data, ram_read_data;

    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt), .a_rd_valid(a_rd_valid),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt), .b_rd_valid(b_rd_valid),
        .rd_data(rd_data),
        .ram_write_enable(ram_write_enable), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_enable(ram_read_enable),
        .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1024x16 RAM with registered read
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_write_addr] <= ram_write_data;
        if (ram_read_enable)  ram_read_data <= mem[ram_read_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Masters are numbered 0 = A, 1 = B, -1 = nobody.
    logic [15:0] shadow [0:1023];
    int          last_w = 1, last_r = 1;
    logic        pend_a = 1'b0, pend_b = 1'b0;
    logic [15:0] pend_d = '0;

    always @(negedge clk) begin : model
        int gw, gc, gr;
        logic [9:0]  wad, rad;
        logic [15:0] wdat;
        logic coll, ren;

        if (!rst_n) begin pend_a = 1'b0; pend_b = 1'b0; end
        chk("m_a_rd_valid", {31'b0, a_rd_valid}, {31'b0, pend_a});
        chk("m_b_rd_valid", {31'b0, b_rd_valid}, {31'b0, pend_b});
        if (pend_a || pend_b) chk("m_rd_data", {16'b0, rd_data}, {16'b0, pend_d});

        gw = -1; gc = -1;
        if (rst_n) begin
            if (a_wr_req && b_wr_req) gw = (last_w == 1) ? 0 : 1;
            else if (a_wr_req)        gw = 0;
            else if (b_wr_req)        gw = 1;
            if (a_rd_req && b_rd_req) gc = (last_r == 1) ? 0 : 1;
            else if (a_rd_req)        gc = 0;
            else if (b_rd_req)        gc = 1;
        end else begin
            last_w = 1; last_r = 1;
        end
        wad  = (gw == 1) ? b_wr_addr : a_wr_addr;
        wdat = (gw == 1) ? b_wr_data : a_wr_data;
        rad  = (gc == 1) ? b_rd_addr : a_rd_addr;
        coll = (gw >= 0) && (gc >= 0) && (rad == wad);
        gr   = gc;
        ren  = (gc >= 0);
        if (coll) begin
            ren = 1'b0;
            if (!FWD) gr = -1;
        end

        chk("m_a_wr_gnt", {31'b0, a_wr_gnt}, {31'b0, gw == 0});
        chk("m_b_wr_gnt", {31'b0, b_wr_gnt}, {31'b0, gw == 1});
        chk("m_a_rd_gnt", {31'b0, a_rd_gnt}, {31'b0, gr == 0});
        chk("m_b_rd_gnt", {31'b0, b_rd_gnt}, {31'b0, gr == 1});
        chk("m_ram_we", {31'b0, ram_write_enable}, {31'b0, gw >= 0});
        chk("m_ram_re", {31'b0, ram_read_enable}, {31'b0, ren});
        if (gw >= 0) begin
            chk("m_ram_waddr", {22'b0, ram_write_addr}, {22'b0, wad});
            chk("m_ram_wdata", {16'b0, ram_write_data}, {16'b0, wdat});
        end
        if (ren) chk("m_ram_raddr", {22'b0, ram_read_addr}, {22'b0, rad});

        pend_a = (gr == 0);
        pend_b = (gr == 1);
        pend_d = coll ? wdat : shadow[rad];
        if (gw >= 0) begin shadow[wad] = wdat; last_w = gw; end
        if (gr >= 0) last_r = gr;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic peek(); @(negedge clk); #1; endtask

    initial begin
        int ka, kb, waits, na, nb, nv, prev, cur;
        logic ga, gb;
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; shadow[i] = '0; end
        ram_read_data = '0;
        rst_n = 1'b0;
        a_wr_req = 1'b1; a_wr_addr = '0; a_wr_data = '0; a_rd_req = 1'b0; a_rd_addr = '0;
        b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_req = 1'b1; b_rd_addr = '0;

        // Reset with requests pending: grants must stay low
        peek();
        chk("rst_a_wr_gnt", {31'b0, a_wr_gnt}, 32'd0);
        chk("rst_b_rd_gnt", {31'b0, b_rd_gnt}, 32'd0);
        tick(); a_wr_req = 1'b0; b_rd_req = 1'b0;
        tick(); rst_n = 1'b1;
        peek();
        chk("rst_a_rd_valid", {31'b0, a_rd_valid}, 32'd0);
        chk("rst_b_rd_valid", {31'b0, b_rd_valid}, 32'd0);

        // A writes 0x3FF <- 0xBEEF, then reads it back
        tick(); a_wr_req = 1'b1; a_wr_addr = 10'h3FF; a_wr_data = 16'hBEEF;
        peek(); chk("t1_a_wr_gnt", {31'b0, a_wr_gnt}, 32'd1);
        tick(); a_wr_req = 1'b0; a_rd_req = 1'b1; a_rd_addr = 10'h3FF;
        peek(); chk("t1_a_rd_gnt", {31'b0, a_rd_gnt}, 32'd1);
        tick(); a_rd_req = 1'b0;
        peek();
        chk("t1_a_rd_valid", {31'b0, a_rd_valid}, 32'd1);
        chk("t1_rd_data", {16'b0, rd_data}, 32'h0000BEEF);
        chk("t1_b_rd_valid", {31'b0, b_rd_valid}, 32'd0);

        // Lone B write so A has priority, then both contend for 4 cycles
        tick(); b_wr_req = 1'b1; b_wr_addr = 10'd2; b_wr_data = 16'h0000;
        peek();
        tick(); a_wr_req = 1'b1; a_wr_addr = 10'd1; a_wr_data = 16'hA000; b_wr_data = 16'hB000;
        ka = 0; kb = 0;
        for (int i = 0; i < 4; i++) begin
            peek();
            chk("t2_a_wr_gnt", {31'b0, a_wr_gnt}, {31'b0, (i % 2) == 0});
            chk("t2_b_wr_gnt", {31'b0, b_wr_gnt}, {31'b0, (i % 2) == 1});
            ga = a_wr_gnt; gb = b_wr_gnt;
            tick();
            if (ga) begin ka++; a_wr_data = 16'hA000 + 16'(ka); end
            if (gb) begin kb++; b_wr_data = 16'hB000 + 16'(kb); end
        end
        a_wr_req = 1'b0; b_wr_req = 1'b0;
        a_rd_req = 1'b1; a_rd_addr = 10'd1;
        peek();
        tick(); a_rd_req = 1'b0; b_rd_req = 1'b1; b_rd_addr = 10'd2;
        peek();
        chk("t2_ram1_valid", {31'b0, a_rd_valid}, 32'd1);
        chk("t2_ram1", {16'b0, rd_data}, 32'h0000A001);
        tick(); b_rd_req = 1'b0;
        peek();
        chk("t2_ram2_valid", {31'b0, b_rd_valid}, 32'd1);
        chk("t2_ram2", {16'b0, rd_data}, 32'h0000B001);

        // Collision: A reads 5 while B writes 5 <- 0x1234 (old value 0x0001)
        tick(); a_wr_req = 1'b1; a_wr_addr = 10'd5; a_wr_data = 16'h0001;
        peek();
        tick(); a_wr_req = 1'b0;
        a_rd_req = 1'b1; a_rd_addr = 10'd5;
        b_wr_req = 1'b1; b_wr_addr = 10'd5; b_wr_data = 16'h1234;
        peek(); chk("t3_b_wr_gnt", {31'b0, b_wr_gnt}, 32'd1);
        waits = 0;
        while (!a_rd_gnt && waits < 4) begin
            tick(); b_wr_req = 1'b0; waits++;
            peek();
        end
        chk("t3_rd_delay", waits, FWD ? 32'd0 : 32'd1);
        chk("t3_a_rd_gnt", {31'b0, a_rd_gnt}, 32'd1);
        tick(); a_rd_req = 1'b0; b_wr_req = 1'b0;
        peek();
        chk("t3_a_rd_valid", {31'b0, a_rd_valid}, 32'd1);
        chk("t3_rd_data", {16'b0, rd_data}, 32'h00001234);

        // Continuous reads from both masters for 8 cycles
        tick(); a_rd_req = 1'b1; a_rd_addr = 10'd1; b_rd_req = 1'b1; b_rd_addr = 10'd2;
        na = 0; nb = 0; nv = 0; prev = -1;
        for (int i = 0; i <= 8; i++) begin
            if (i == 8) begin a_rd_req = 1'b0; b_rd_req = 1'b0; end
            peek();
            if (i > 0) begin
                cur = a_rd_valid ? 0 : (b_rd_valid ? 1 : -1);
                if (a_rd_valid) begin nv++; chk("t4_a_data", {16'b0, rd_data}, 32'h0000A001); end
                if (b_rd_valid) begin nv++; chk("t4_b_data", {16'b0, rd_data}, 32'h0000B001); end
                if (i > 1) chk("t4_alternate", {31'b0, cur != prev}, 32'd1);
                prev = cur;
            end
            if (i < 8) begin
                if (a_rd_gnt) na++;
                if (b_rd_gnt) nb++;
            end
            tick();
        end
        chk("t4_valids", nv, 32'd8);
        chk("t4_a_grants", na, 32'd4);
        chk("t4_b_grants", nb, 32'd4);

        // Reset right after a B read grant: its valid must never appear
        b_rd_req = 1'b1; b_rd_addr = 10'd2;
        peek(); chk("t5_b_rd_gnt", {31'b0, b_rd_gnt}, 32'd1);
        rst_n = 1'b0; b_rd_req = 1'b0;
        a_wr_req = 1'b1; a_wr_addr = 10'd7; a_wr_data = 16'h0707;
        b_wr_req = 1'b1; b_wr_addr = 10'd8; b_wr_data = 16'h0808;
        tick(); peek();
        chk("t5_b_rd_valid_rst", {31'b0, b_rd_valid}, 32'd0);
        chk("t5_a_wr_gnt_rst", {31'b0, a_wr_gnt}, 32'd0);
        chk("t5_b_wr_gnt_rst", {31'b0, b_wr_gnt}, 32'd0);
        tick(); rst_n = 1'b1;
        peek();
        chk("t5_first_a", {31'b0, a_wr_gnt}, 32'd1);
        chk("t5_first_b", {31'b0, b_wr_gnt}, 32'd0);
        chk("t5_b_rd_valid_rel", {31'b0, b_rd_valid}, 32'd0);
        tick(); a_wr_req = 1'b0;
        peek(); chk("t5_then_b", {31'b0, b_wr_gnt}, 32'd1);
        tick(); b_wr_req = 1'b0;
        peek();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
